// File: rtl/cu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// cu_cmd_issuer
// Sequential command issuer for the channel-select control decoder. A channel
// request is accepted over valid/ready. The decoder code lines are then walked
// through PARK -> SELECT -> COMMIT. The decoder's one-hot strobe and commit ack
// are checked, and a status response is returned over valid/ready. The decoder
// itself is purely combinational, so all sequencing lives here.
//
// Parameters
//   SEL_CYCLES : cycles the SELECT code is held (>=1); strobe sampled on last
//   TIMEOUT    : max cycles spent in COMMIT waiting for dec_ack (>=1)
//   ERRW       : width of the saturating error counter
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   req_valid   in   request present
//   req_ready   out  high only in IDLE
//   req_chan    in   channel to select {b,a}
//   rsp_valid   out  response present, held until rsp_ready
//   rsp_ready   in   response consumed
//   rsp_status  out  00 OK, 01 SEL_MISMATCH, 10 TIMEOUT
//   rsp_chan    out  echo of the accepted req_chan
//   dec_a/dec_b out  channel select lines (a = chan[0], b = chan[1])
//   dec_c..f    out  phase code lines {c,d,e,f}
//   dec_o       out  mode line, tied to command mode (0)
//   dec_sel     in   decoder one-hot channel strobes
//   dec_ack     in   decoder commit ack
//   err_count   out  saturating count of non-OK responses
// -----------------------------------------------------------------------------
module cu_cmd_issuer #(
  parameter int SEL_CYCLES = 2,
  parameter int TIMEOUT    = 8,
  parameter int ERRW       = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_chan,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [1:0]      rsp_status,
  output logic [1:0]      rsp_chan,
  output logic            dec_a,
  output logic            dec_b,
  output logic            dec_c,
  output logic            dec_d,
  output logic            dec_e,
  output logic            dec_f,
  output logic            dec_o,
  input  logic [3:0]      dec_sel,
  input  logic            dec_ack,
  output logic [ERRW-1:0] err_count
);

  localparam int SCW = (SEL_CYCLES > 1) ? $clog2(SEL_CYCLES) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SCW-1:0] SEL_LAST = SCW'(SEL_CYCLES - 1);
  localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT - 1);

  // Phase codes on {c,d,e,f}; PARK (d=1) holds every decoder strobe low.
  localparam logic [3:0] CODE_PARK   = 4'b0100;
  localparam logic [3:0] CODE_SELECT = 4'b0001;
  localparam logic [3:0] CODE_COMMIT = 4'b1010;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_MISMATCH = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SELECT = 2'b01,
    S_COMMIT = 2'b10,
    S_RESP   = 2'b11
  } state_t;

  state_t          r_state;
  logic [3:0]      r_code;
  logic            r_a;
  logic            r_b;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [1:0]      r_status;
  logic [1:0]      r_chan;
  logic [ERRW-1:0] r_err;
  logic [SCW-1:0]  r_sel_cnt;
  logic [TW-1:0]   r_tmr;

  logic [3:0]      w_exp_sel;
  logic            w_sel_ok;
  logic [ERRW-1:0] w_err_inc;
  logic [1:0]      w_commit_status;

  // Only the exact one-hot of the latched channel is a match; zero,
  // multi-hot and wrong-bit strobes all fall into the mismatch path.
  assign w_exp_sel = 4'b0001 << r_chan;
  assign w_sel_ok  = (dec_sel == w_exp_sel);

  // Error counter sticks at all-ones instead of wrapping.
  assign w_err_inc = (&r_err) ? r_err : (r_err + ERRW'(1'b1));

  // An ack on the final COMMIT cycle still wins over the timeout.
  assign w_commit_status = dec_ack ? ST_OK : ST_TIMEOUT;

  // Command sequencer: owns the decoder code lines, handshakes and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_code      <= CODE_PARK;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_status    <= ST_OK;
      r_chan      <= 2'b00;
      r_err       <= '0;
      r_sel_cnt   <= '0;
      r_tmr       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_chan      <= req_chan;
            r_a         <= req_chan[0];
            r_b         <= req_chan[1];
            r_code      <= CODE_SELECT;
            r_req_ready <= 1'b0;
            r_sel_cnt   <= '0;
            r_state     <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (r_sel_cnt == SEL_LAST) begin
            if (w_sel_ok) begin
              r_code  <= CODE_COMMIT;
              r_tmr   <= '0;
              r_state <= S_COMMIT;
            end else begin
              r_code      <= CODE_PARK;
              r_a         <= 1'b0;
              r_b         <= 1'b0;
              r_status    <= ST_MISMATCH;
              r_rsp_valid <= 1'b1;
              r_err       <= w_err_inc;
              r_state     <= S_RESP;
            end
          end else begin
            r_sel_cnt <= r_sel_cnt + SCW'(1'b1);
          end
        end

        S_COMMIT: begin
          if (dec_ack || (r_tmr == TMR_LAST)) begin
            r_code      <= CODE_PARK;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_status    <= w_commit_status;
            r_rsp_valid <= 1'b1;
            if (!dec_ack) begin
              r_err <= w_err_inc;
            end
            r_state     <= S_RESP;
          end else begin
            r_tmr <= r_tmr + TW'(1'b1);
          end
        end

        S_RESP: begin
          // New requests are not queued here; req_ready stays low until IDLE.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_code      <= CODE_PARK;
          r_a         <= 1'b0;
          r_b         <= 1'b0;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_status = r_status;
  assign rsp_chan   = r_chan;
  assign dec_a      = r_a;
  assign dec_b      = r_b;
  assign {dec_c, dec_d, dec_e, dec_f} = r_code;
  assign dec_o      = 1'b0;
  assign err_count  = r_err;

endmodule

// File: tb/tb_cu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_cu_cmd_issuer
// Directed bench for cu_cmd_issuer. The bench plays the combinational decoder,
// drives requests and pushes the hand-computed expected response into a queue.
// A separate monitor pops and compares on each response handshake. A second
// instance with ERRW=2 shares all stimulus so error-counter saturation is seen.
// -----------------------------------------------------------------------------
module tb_cu_cmd_issuer;

  localparam logic [3:0] PARK   = 4'b0100;
  localparam logic [3:0] SEL    = 4'b0001;
  localparam logic [3:0] COMMIT = 4'b1010;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_chan;
  logic       rsp_ready;

  // instance 1 (ERRW=8)
  logic       req_ready, rsp_valid;
  logic [1:0] rsp_status, rsp_chan;
  logic       dec_a, dec_b, dec_c, dec_d, dec_e, dec_f, dec_o;
  logic [3:0] dec_sel;
  logic       dec_ack;
  logic [7:0] err_count;

  // instance 2 (ERRW=2)
  logic       req_ready2, rsp_valid2;
  logic [1:0] rsp_status2, rsp_chan2;
  logic       dec_a2, dec_b2, dec_c2, dec_d2, dec_e2, dec_f2, dec_o2;
  logic [3:0] dec_sel2;
  logic       dec_ack2;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  // decoder model controls: 0 correct, 1 fixed 0001, 2 zero, 3 correct|1000
  int   sel_mode = 0;
  int   ack_at   = -1;   // COMMIT cycle index (0-based) carrying ack, -1 never
  logic ack_any  = 1'b0; // drive ack in every non-COMMIT cycle

  typedef struct {
    logic [1:0] st;
    logic [1:0] ch;
    logic [7:0] err;
    logic [1:0] err2;
  } exp_t;

  exp_t q[$];
  int   exp_err  = 0;
  int   exp_err2 = 0;

  cu_cmd_issuer #(.SEL_CYCLES(2), .TIMEOUT(8), .ERRW(8)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_chan(rsp_chan),
    .dec_a(dec_a), .dec_b(dec_b), .dec_c(dec_c), .dec_d(dec_d),
    .dec_e(dec_e), .dec_f(dec_f), .dec_o(dec_o),
    .dec_sel(dec_sel), .dec_ack(dec_ack), .err_count(err_count)
  );

  cu_cmd_issuer #(.SEL_CYCLES(2), .TIMEOUT(8), .ERRW(2)) u_dut2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready2), .req_chan(req_chan),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status2), .rsp_chan(rsp_chan2),
    .dec_a(dec_a2), .dec_b(dec_b2), .dec_c(dec_c2), .dec_d(dec_d2),
    .dec_e(dec_e2), .dec_f(dec_f2), .dec_o(dec_o2),
    .dec_sel(dec_sel2), .dec_ack(dec_ack2), .err_count(err_count2)
  );

  always #5 clock = ~clock;

  logic [3:0] code, code2;
  assign code  = {dec_c, dec_d, dec_e, dec_f};
  assign code2 = {dec_c2, dec_d2, dec_e2, dec_f2};

  // count of completed COMMIT cycles, used to place the ack
  int ccnt = 0;
  int ccnt2 = 0;
  always @(posedge clock) begin
    ccnt  <= (code  == COMMIT) ? ccnt  + 1 : 0;
    ccnt2 <= (code2 == COMMIT) ? ccnt2 + 1 : 0;
  end

  function automatic logic [3:0] sel_model(input logic [3:0] c, input logic [1:0] ch, input int mode);
    logic [3:0] good;
    good = 4'b0001 << ch;
    if (c != SEL) return 4'b0000;
    case (mode)
      1:       return 4'b0001;
      2:       return 4'b0000;
      3:       return good | 4'b1000;
      default: return good;
    endcase
  endfunction

  function automatic logic ack_model(input logic [3:0] c, input int cnt, input int at, input logic any);
    if (c == COMMIT) return (cnt == at);
    return any;
  endfunction

  assign dec_sel  = sel_model(code,  {dec_b,  dec_a},  sel_mode);
  assign dec_sel2 = sel_model(code2, {dec_b2, dec_a2}, sel_mode);
  assign dec_ack  = ack_model(code,  ccnt,  ack_at, ack_any);
  assign dec_ack2 = ack_model(code2, ccnt2, ack_at, ack_any);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void push_exp(input logic [1:0] st, input logic [1:0] ch);
    exp_t e;
    if (st != 2'b00) begin
      exp_err++;
      exp_err2 = (exp_err2 == 3) ? 3 : exp_err2 + 1;
    end
    e.st   = st;
    e.ch   = ch;
    e.err  = 8'(exp_err);
    e.err2 = 2'(exp_err2);
    q.push_back(e);
  endfunction

  // scoreboard monitor: compare on every response handshake
  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got status %0h chan %0h expected no response", rsp_status, rsp_chan);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_status",  32'(rsp_status),  32'(e.st));
        chk("rsp_chan",    32'(rsp_chan),    32'(e.ch));
        chk("err_count",   32'(err_count),   32'(e.err));
        chk("rsp2_valid",  32'(rsp_valid2),  32'(1'b1));
        chk("rsp2_status", 32'(rsp_status2), 32'(e.st));
        chk("err_count2",  32'(err_count2),  32'(e.err2));
      end
    end
  end

  // wait for req_ready, present one request, leave after the accepting edge
  task automatic start_req(input logic [1:0] ch, input bit push, input logic [1:0] st);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 50 cycles");
    end
    req_valid = 1'b1;
    req_chan  = ch;
    if (push) push_exp(st, ch);
    tick();
    req_valid = 1'b0;
  endtask

  // called one cycle after acceptance; latency counts edges incl. the accept edge
  task automatic wait_rsp(input int exp_lat, input int exp_commits);
    int lat = 1;
    int commits = 0;
    while (!rsp_valid && lat < 100) begin
      if (code == COMMIT) commits++;
      tick();
      lat++;
    end
    chk("latency",        32'(lat),       32'(exp_lat));
    chk("commit_cycles",  32'(commits),   32'(exp_commits));
    chk("resp_code_park", 32'(code),      32'(PARK));
    chk("resp_ab_zero",   32'({dec_b, dec_a}), 32'(2'b00));
    chk("resp_req_ready", 32'(req_ready), 32'(1'b0));
  endtask

  task automatic run(input logic [1:0] ch, input int mode, input int at, input logic any,
                     input logic [1:0] st, input int lat, input int commits);
    sel_mode = mode;
    ack_at   = at;
    ack_any  = any;
    start_req(ch, 1'b1, st);
    wait_rsp(lat, commits);
    tick();
  endtask

  logic [1:0] sat_tbl [5];
  logic [1:0] held_status;

  initial begin
    sat_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset     = 1'b1;
    req_valid = 1'b0;
    req_chan  = 2'b00;
    rsp_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    chk("rst_req_ready", 32'(req_ready),  32'(1'b1));
    chk("rst_rsp_valid", 32'(rsp_valid),  32'(1'b0));
    chk("rst_status",    32'(rsp_status), 32'(2'b00));
    chk("rst_chan",      32'(rsp_chan),   32'(2'b00));
    chk("rst_code",      32'(code),       32'(PARK));
    chk("rst_ab",        32'({dec_b, dec_a}), 32'(2'b00));
    chk("rst_dec_o",     32'(dec_o),      32'(1'b0));
    chk("rst_err",       32'(err_count),  32'(8'd0));

    // OK path, ack in second COMMIT cycle; then minimum latency, ack in first
    run(2'd2, 0, 1, 1'b0, 2'b00, 5, 2);
    run(2'd0, 0, 0, 1'b0, 2'b00, 4, 1);

    // strobe mismatches: wrong bit, zero, multi-hot
    run(2'd1, 1, 0, 1'b0, 2'b01, 3, 0);
    run(2'd0, 2, 0, 1'b0, 2'b01, 3, 0);
    run(2'd2, 3, 0, 1'b0, 2'b01, 3, 0);

    // timeout with ack outside COMMIT (ignored); then ack on the last cycle
    run(2'd3, 0, -1, 1'b1, 2'b10, 11, 8);
    run(2'd3, 0, 7, 1'b0, 2'b00, 11, 8);

    // response back-pressure with a request that must be ignored meanwhile
    sel_mode  = 0;
    ack_at    = 0;
    ack_any   = 1'b0;
    rsp_ready = 1'b0;
    start_req(2'd1, 1'b1, 2'b00);
    wait_rsp(4, 1);
    held_status = rsp_status;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_chan  = 2'd3;
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid),  32'(1'b1));
      chk("hold_status",    32'(rsp_status), 32'(held_status));
      chk("hold_chan",      32'(rsp_chan),   32'(2'd1));
      chk("hold_req_ready", 32'(req_ready),  32'(1'b0));
      chk("hold_code",      32'(code),       32'(PARK));
    end
    rsp_ready = 1'b1;
    tick();
    chk("post_hs_req_ready", 32'(req_ready), 32'(1'b1));
    chk("post_hs_rsp_valid", 32'(rsp_valid), 32'(1'b0));
    push_exp(2'b00, 2'd3);
    tick();
    req_valid = 1'b0;
    chk("next_accept_ready", 32'(req_ready), 32'(1'b0));
    chk("next_accept_code",  32'(code),      32'(SEL));
    wait_rsp(4, 1);
    tick();

    // reset in the middle of COMMIT
    sel_mode = 0;
    ack_at   = -1;
    ack_any  = 1'b0;
    start_req(2'd2, 1'b0, 2'b00);
    for (int n = 0; n < 20 && code != COMMIT; n++) tick();
    chk("reach_commit", 32'(code), 32'(COMMIT));
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_code",      32'(code),      32'(PARK));
    chk("mid_rst_ab",        32'({dec_b, dec_a}), 32'(2'b00));
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
    chk("mid_rst_err",       32'(err_count), 32'(8'd0));
    chk("mid_rst_err2",      32'(err_count2), 32'(2'd0));
    reset    = 1'b0;
    exp_err  = 0;
    exp_err2 = 0;
    tick();
    chk("mid_rst_req_ready", 32'(req_ready), 32'(1'b1));

    // five timeouts: ERRW=2 saturates at 3, ERRW=8 keeps counting
    for (int i = 0; i < 5; i++) begin
      sel_mode = 0;
      ack_at   = -1;
      ack_any  = 1'b0;
      start_req(2'd0, 1'b1, 2'b10);
      wait_rsp(11, 8);
      chk("sat_err2", 32'(err_count2), 32'(sat_tbl[i]));
      chk("sat_err8", 32'(err_count),  32'(i + 1));
      tick();
    end

    repeat (3) tick();
    chk("scoreboard_empty", 32'(q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
